// File: rtl/reboot_ctrl_pkg.sv
// rtl/reboot_ctrl_pkg.sv - shared types and defaults for reboot_request_ctrl (REBOOT_HOTKEY_EN build option)
package reboot_ctrl_pkg;

  typedef logic [23:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HOLD,
    ST_LOCKED
  } state_e;

  localparam addr_t DEF_BASE_ADDR = 24'h000000;
  localparam addr_t DEF_SLOT_SIZE = 24'h058000;

  // Wraps to 24 bits, matching the flash address space.
  function automatic addr_t slot_addr(input addr_t base, input addr_t stride, input addr_t slot);
    return base + slot * stride;
  endfunction

endpackage

// File: rtl/hotkey_hold_detect.sv
// rtl/hotkey_hold_detect.sv - one-cycle fire after hotkey held HOLD_CYCLES cycles; used only with REBOOT_HOTKEY_EN
module hotkey_hold_detect #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hotkey,
  output logic fire
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating at HOLD_CYCLES means fire happens once per continuous hold.
  always_comb begin
    cnt_d = '0;
    if (hotkey) begin
      cnt_d = (cnt_q == CW'(HOLD_CYCLES)) ? cnt_q : cnt_q + CW'(1);
    end
  end

  assign fire = hotkey && (cnt_q == CW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reboot_request_ctrl.sv
// rtl/reboot_request_ctrl.sv - arm/confirm guarded reboot request front-end for ICAP multiboot; REBOOT_HOTKEY_EN adds hotkey reboot
module reboot_request_ctrl
  import reboot_ctrl_pkg::*;
#(
  parameter int    SLOT_BITS     = 3,
  parameter int    SLOT_COUNT    = 6,
  parameter addr_t BASE_ADDR     = DEF_BASE_ADDR,
  parameter addr_t SLOT_SIZE     = DEF_SLOT_SIZE,
  parameter int    HOLD_CYCLES   = 16,
  parameter int    ARM_TIMEOUT   = 1_000_000,
  parameter int    HOTKEY_CYCLES = 50_000_000
) (
  input  logic                 clk_icap,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic                 req_valid,
  input  logic [SLOT_BITS-1:0] req_slot,
  output logic                 req_ready,
  input  logic                 hotkey,
  output logic                 REBOOT,
  output logic [23:0]          spi_addr,
  output logic                 busy,
  output logic                 err
);

  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  addr_t         spi_addr_q, spi_addr_d;
  logic          req_ready_q, req_ready_d;
  logic          reboot_q, reboot_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          hk_fire;
  logic          accept;
  logic          slot_ok;

`ifdef REBOOT_HOTKEY_EN
  hotkey_hold_detect #(
    .HOLD_CYCLES(HOTKEY_CYCLES)
  ) u_hotkey (
    .clk    (clk_icap),
    .reset_n(reset_n),
    .hotkey (hotkey),
    .fire   (hk_fire)
  );
`else
  logic unused_hotkey;
  assign unused_hotkey = hotkey ^ (HOTKEY_CYCLES < 0);
  assign hk_fire = 1'b0;
`endif

  assign accept  = (state_q == ST_ARMED) && req_valid;
  assign slot_ok = 32'(req_slot) < SLOT_COUNT;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    spi_addr_d = spi_addr_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hk_fire) begin
          spi_addr_d = BASE_ADDR;
          hold_d     = HW'(HOLD_CYCLES - 1);
          state_d    = ST_HOLD;
        end else if (arm) begin
          tmo_d   = TW'(ARM_TIMEOUT);
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Accept wins over timeout expiry, re-arm and hotkey completion.
        if (accept) begin
          tmo_d = '0;
          if (slot_ok) begin
            spi_addr_d = slot_addr(BASE_ADDR, SLOT_SIZE, addr_t'(req_slot));
            hold_d     = HW'(HOLD_CYCLES - 1);
            state_d    = ST_HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (hk_fire) begin
          tmo_d      = '0;
          spi_addr_d = BASE_ADDR;
          hold_d     = HW'(HOLD_CYCLES - 1);
          state_d    = ST_HOLD;
        end else if (arm) begin
          tmo_d = TW'(ARM_TIMEOUT);
        end else if (tmo_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode the next state so they are registered yet aligned with it.
  always_comb begin
    req_ready_d = (state_d == ST_ARMED);
    reboot_d    = (state_d == ST_HOLD);
    busy_d      = (state_d == ST_HOLD) || (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_icap) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      hold_q      <= '0;
      spi_addr_q  <= BASE_ADDR;
      req_ready_q <= 1'b0;
      reboot_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
      spi_addr_q  <= spi_addr_d;
      req_ready_q <= req_ready_d;
      reboot_q    <= reboot_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign REBOOT    = reboot_q;
  assign spi_addr  = spi_addr_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
